bkpt_unit: RTL
==============

# bkpt_unit

Multi-channel, parametrised breakpoint unit for the BK-0010 debug path. It watches the CPU bus, matches per-channel masked address (and optionally data) patterns qualified by access kind, and applies pass counts. It raises a halt request to the CPU sequencer, holds hit status until the debugger resumes, and replaces the single combinational comparator with a configurable, stateful block.

## Interface
Parameters:
- WIDTH, 16, bus address/data width
- CHANNELS, 4, number of breakpoint channels (1..8)
- CNT_W, 8, pass-count width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_valid  in  1  bus cycle present this clk
- bus_kind  in  2  00 fetch, 01 read, 10 write, 11 ignored (never matches)
- bus_addr  in  WIDTH  bus address
- bus_data  in  WIDTH  bus data (used only with BKPT_DATA_MATCH_EN)
- cfg_we  in  1  config write strobe
- cfg_ch  in  3  channel index; writes with cfg_ch >= CHANNELS are dropped
- cfg_sel  in  3  0 addr match, 1 addr mask, 2 ctrl, 3 pass count, 4 data match, 5 data mask
- cfg_wdata  in  WIDTH  config write data
- cfg_rdata  out  WIDTH  registered readback of (cfg_ch, cfg_sel), one clk latency
- halt_req  out  1  halt request to CPU sequencer
- halt_ack  in  1  CPU has stopped
- resume  in  1  debugger resume pulse
- halted  out  1  unit in HALTED state
- hit_vec  out  CHANNELS  sticky per-channel fire flags
- hit_addr  out  WIDTH  bus_addr of the first firing cycle

## Operation
- Compare: channel matches when ((bus_addr ^ amatch) & amask) == 0. Mask bit 1 = compare, 0 = don't care. Mask 0 matches every address.
- ctrl bits: [0] enable, [1] fetch, [2] read, [3] write, [4] one-shot; other bits read 0.
- A qualifying match needs all of: bus_valid, enable, the kind bit set, the address compare true, and FSM in IDLE.
- Pass count: on a qualifying match, count > 0 decrements the count with no fire. count == 0 fires. After firing, count stays 0. One-shot clears enable on fire.
- FSM states:
  - IDLE: any fire sets the hit_vec bits, captures hit_addr and goes to REQ.
  - REQ: halt_req = 1. halt_ack moves to HALTED.
  - HALTED: halted = 1, halt_req = 0. resume clears hit_vec and goes to IDLE.
- resume in IDLE or REQ has no effect.
- In REQ and HALTED, bus matches are ignored and counts are frozen.
- Simultaneous fires on several channels set all their bits. hit_addr is shared.
- A cfg write to a channel in the same clk as its match: the write wins, and that channel's match is discarded. Other channels are unaffected.
- cfg writes are accepted in every state.

## Timing
- Bus cycle at edge N produces hit_vec/hit_addr/halt_req at edge N+1 (one registered stage).
- halt_ack sampled in REQ produces halted = 1 and halt_req = 0 at the next edge.
- resume sampled in HALTED produces halted = 0 and hit_vec = 0 at the next edge. A bus match on the following clk can fire again.
- cfg write at edge N takes effect for bus cycles sampled at edge N+1 onward.
- Reset (asynchronous, any state, including mid-REQ):
  - FSM returns to IDLE.
  - halt_req, halted, hit_vec, hit_addr, cfg_rdata all go to 0.
  - All match, mask, ctrl and count registers go to 0, so every channel is disabled.

## Configuration
- BKPT_DATA_MATCH_EN defined:
  - Each channel adds dmatch/dmask registers (cfg_sel 4/5, reset 0).
  - The qualifying match additionally requires ((bus_data ^ dmatch) & dmask) == 0.
- BKPT_DATA_MATCH_EN undefined:
  - There are no data registers, and bus_data is unused.
  - cfg_sel 4/5 writes are dropped and read back 0.

## Test plan
- Reset, then a fetch at 0o100000 with all channels idle -> halt_req stays 0, hit_vec = 0.
- ch0 amatch = 0o001000, amask = 0o177770, ctrl = fetch|enable; fetch 0o001006 -> hit_vec = 4'b0001, hit_addr = 0o001006, halt_req one clk later. halt_ack -> halted = 1. resume -> hit_vec = 0, back to IDLE.
- ch1 write-only, count = 2; three writes to its address -> no fire on the first two, fire on the third; a read to the same address never fires.
- ch0 and ch2 both match the same fetch -> hit_vec = 4'b0101. A further match during REQ leaves count unchanged; a cfg write colliding with a match drops that channel's hit.
- One-shot ch3 fires, resume, same access again -> no fire, ctrl readback bit0 = 0. Reset asserted during REQ -> all outputs 0 immediately.
- With BKPT_DATA_MATCH_EN: ch0 dmatch = 0o000377, dmask = 0o177777; write 0o000377 fires, write 0o000376 does not. Without the macro: same stimulus fires on both.

Source files
------------

// File: rtl/bkpt_unit.sv
// Multi-channel breakpoint unit: masked address (and optionally data) match with pass counts and a halt handshake.
// Optional data matching is enabled with `define BKPT_DATA_MATCH_EN.
module bkpt_unit #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_valid,
    input  logic [1:0]          bus_kind,
    input  logic [WIDTH-1:0]    bus_addr,
    input  logic [WIDTH-1:0]    bus_data,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_ch,
    input  logic [2:0]          cfg_sel,
    input  logic [WIDTH-1:0]    cfg_wdata,
    output logic [WIDTH-1:0]    cfg_rdata,
    output logic                halt_req,
    input  logic                halt_ack,
    input  logic                resume,
    output logic                halted,
    output logic [CHANNELS-1:0] hit_vec,
    output logic [WIDTH-1:0]    hit_addr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]    r_amatch [CHANNELS];
    logic [WIDTH-1:0]    r_amask  [CHANNELS];
    logic [4:0]          r_ctrl   [CHANNELS];
    logic [CNT_W-1:0]    r_count  [CHANNELS];
`ifdef BKPT_DATA_MATCH_EN
    logic [WIDTH-1:0]    r_dmatch [CHANNELS];
    logic [WIDTH-1:0]    r_dmask  [CHANNELS];
`else
    logic                w_unused_data;
    assign w_unused_data = ^bus_data;
`endif

    logic [1:0]          r_state;
    logic [CHANNELS-1:0] r_hit_vec;
    logic [WIDTH-1:0]    r_hit_addr;
    logic [WIDTH-1:0]    r_rdata;

    logic [CHANNELS-1:0] w_cfg_hit;
    logic [CHANNELS-1:0] w_kind_ok;
    logic [CHANNELS-1:0] w_addr_ok;
    logic [CHANNELS-1:0] w_data_ok;
    logic [CHANNELS-1:0] w_qual;
    logic [CHANNELS-1:0] w_fire;
    logic [WIDTH-1:0]    w_rdata;

    // A config write to a channel discards that channel's match in the same cycle.
    always_comb begin
        w_cfg_hit = '0;
        w_kind_ok = '0;
        w_addr_ok = '0;
        w_data_ok = '0;
        w_qual    = '0;
        w_fire    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_cfg_hit[c] = cfg_we && (cfg_ch == 3'(c));
            case (bus_kind)
                2'b00:   w_kind_ok[c] = r_ctrl[c][1];
                2'b01:   w_kind_ok[c] = r_ctrl[c][2];
                2'b10:   w_kind_ok[c] = r_ctrl[c][3];
                default: w_kind_ok[c] = 1'b0;
            endcase
            w_addr_ok[c] = (((bus_addr ^ r_amatch[c]) & r_amask[c]) == '0);
`ifdef BKPT_DATA_MATCH_EN
            w_data_ok[c] = (((bus_data ^ r_dmatch[c]) & r_dmask[c]) == '0);
`else
            w_data_ok[c] = 1'b1;
`endif
            w_qual[c] = bus_valid && r_ctrl[c][0] && w_kind_ok[c] && w_addr_ok[c]
                        && w_data_ok[c] && (r_state == S_IDLE) && !w_cfg_hit[c];
            w_fire[c] = w_qual[c] && (r_count[c] == '0);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_ch == 3'(c)) begin
                case (cfg_sel)
                    3'd0:    w_rdata = r_amatch[c];
                    3'd1:    w_rdata = r_amask[c];
                    3'd2:    w_rdata[4:0] = r_ctrl[c];
                    3'd3:    w_rdata[CNT_W-1:0] = r_count[c];
`ifdef BKPT_DATA_MATCH_EN
                    3'd4:    w_rdata = r_dmatch[c];
                    3'd5:    w_rdata = r_dmask[c];
`endif
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_amatch[c] <= '0;
                r_amask[c]  <= '0;
                r_ctrl[c]   <= '0;
                r_count[c]  <= '0;
`ifdef BKPT_DATA_MATCH_EN
                r_dmatch[c] <= '0;
                r_dmask[c]  <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_cfg_hit[c]) begin
                    case (cfg_sel)
                        3'd0:    r_amatch[c] <= cfg_wdata;
                        3'd1:    r_amask[c]  <= cfg_wdata;
                        3'd2:    r_ctrl[c]   <= cfg_wdata[4:0];
                        3'd3:    r_count[c]  <= cfg_wdata[CNT_W-1:0];
`ifdef BKPT_DATA_MATCH_EN
                        3'd4:    r_dmatch[c] <= cfg_wdata;
                        3'd5:    r_dmask[c]  <= cfg_wdata;
`endif
                        default: ;
                    endcase
                end else begin
                    if (w_qual[c] && (r_count[c] != '0))
                        r_count[c] <= r_count[c] - CNT_ONE;
                    if (w_fire[c] && r_ctrl[c][4])
                        r_ctrl[c][0] <= 1'b0;
                end
            end
        end
    end

    // Halt handshake: IDLE -> REQ on fire, REQ -> HALTED on ack, HALTED -> IDLE on resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hit_vec  <= '0;
            r_hit_addr <= '0;
            r_rdata    <= '0;
        end else begin
            r_rdata <= w_rdata;
            case (r_state)
                S_IDLE: begin
                    if (w_fire != '0) begin
                        r_hit_vec  <= r_hit_vec | w_fire;
                        r_hit_addr <= bus_addr;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (halt_ack)
                        r_state <= S_HALTED;
                end
                S_HALTED: begin
                    if (resume) begin
                        r_hit_vec <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign halt_req  = (r_state == S_REQ);
    assign halted    = (r_state == S_HALTED);
    assign hit_vec   = r_hit_vec;
    assign hit_addr  = r_hit_addr;
    assign cfg_rdata = r_rdata;

endmodule
